// File: rtl/sdi_rx_rate_scan_if.sv
// Receiver-facing signals of the SDI rate scanner: status from the receiver,
// one-hot rate control back to it.
interface sdi_rx_rate_scan_if;
   logic       vid_active;
   logic       trs_out;
   logic       eav_error;
   logic       sav_error;
   logic       y1_crc_error;
   logic       c1_crc_error;
   logic       rx_tg_hdn;
   logic       rx_hd_sdn;
   logic [2:0] rx_rate;

   // The scan controller owns rx_rate; the receiver owns everything else.
   modport master (
      input  vid_active, trs_out, eav_error, sav_error,
      input  y1_crc_error, c1_crc_error, rx_tg_hdn, rx_hd_sdn,
      output rx_rate
   );

   modport slave (
      output vid_active, trs_out, eav_error, sav_error,
      output y1_crc_error, c1_crc_error, rx_tg_hdn, rx_hd_sdn,
      input  rx_rate
   );
endinterface

// File: rtl/sdi_rx_rate_scan.sv
// SDI receiver rate scanner: cycles 3G/HD/SD until video and clean TRS are seen,
// then holds lock with loss hysteresis; supports a manual rate override.
module sdi_rx_rate_scan #(
   parameter int DWELL_CYCLES = 65536,
   parameter int TRS_GOOD     = 8,
   parameter int LOSS_CYCLES  = 4096
) (
   input  logic                      rx_clk,
   input  logic                      rst,
   sdi_rx_rate_scan_if.master        rx,
   input  logic                      force_rate_en,
   input  logic [1:0]                force_rate,
   output logic                      locked,
   output logic [1:0]                scan_state,
   output logic [7:0]                relock_count,
   output logic [15:0]               crc_err_count
);

   localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
   localparam int TRS_W   = $clog2(TRS_GOOD + 1);
   localparam int LOSS_W  = $clog2(LOSS_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_SCAN   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2,
      ST_LOST   = 2'd3
   } state_t;

   // Scan order is 3G -> HD -> SD -> 3G, i.e. a right rotation of the one-hot code.
   function automatic logic [2:0] rate_advance(input logic [2:0] r);
      return {r[0], r[2:1]};
   endfunction

   function automatic logic [2:0] force_onehot(input logic [1:0] fr);
      logic [2:0] oh;
      case (fr)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         default: oh = 3'b100;
      endcase
      return oh;
   endfunction

   function automatic logic rate_match(input logic [2:0] r, input logic tg_hdn, input logic hd_sdn);
      logic m;
      case (r)
         3'b100:  m = tg_hdn;
         3'b010:  m = ~tg_hdn & hd_sdn;
         3'b001:  m = ~hd_sdn;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   state_t              state_r, state_s;
   logic [2:0]          rate_r, rate_s;
   logic [DWELL_W-1:0]  dwell_r, dwell_s;
   logic [TRS_W-1:0]    trs_r, trs_s;
   logic [LOSS_W-1:0]   loss_r, loss_s;
   logic                locked_r, locked_s;
   logic [7:0]          relock_r, relock_s;
   logic [15:0]         crc_r, crc_s;
   logic                force_en_d_r;
   logic [1:0]          force_rate_d_r;

   logic                dwell_exp_s;
   logic                clean_trs_s;
   logic                force_evt_s;
   logic [2:0]          forced_s;
   logic [2:0]          next_rate_s;
   logic                match_s;

   // State and counter registers with synchronous reset.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state_r        <= ST_SCAN;
         rate_r         <= 3'b100;
         dwell_r        <= '0;
         trs_r          <= '0;
         loss_r         <= '0;
         locked_r       <= 1'b0;
         relock_r       <= 8'd0;
         crc_r          <= 16'd0;
         force_en_d_r   <= 1'b0;
         force_rate_d_r <= 2'd0;
      end else begin
         state_r        <= state_s;
         rate_r         <= rate_s;
         dwell_r        <= dwell_s;
         trs_r          <= trs_s;
         loss_r         <= loss_s;
         locked_r       <= locked_s;
         relock_r       <= relock_s;
         crc_r          <= crc_s;
         force_en_d_r   <= force_rate_en;
         force_rate_d_r <= force_rate;
      end
   end

   // Next-state, rate and counter logic.
   always_comb begin
      state_s  = state_r;
      rate_s   = rate_r;
      dwell_s  = dwell_r;
      trs_s    = trs_r;
      loss_s   = loss_r;
      locked_s = locked_r;
      relock_s = relock_r;
      crc_s    = crc_r;

      dwell_exp_s = (dwell_r == DWELL_W'(DWELL_CYCLES - 1));
      clean_trs_s = rx.trs_out & ~rx.eav_error & ~rx.sav_error;
      force_evt_s = force_rate_en & (~force_en_d_r | (force_rate != force_rate_d_r));
      forced_s    = force_onehot(force_rate);
      // While forced, an expiring dwell wraps without touching the rate.
      next_rate_s = force_rate_en ? forced_s : rate_advance(rate_r);
      match_s     = rate_match(rate_r, rx.rx_tg_hdn, rx.rx_hd_sdn);

      if (force_evt_s) begin
         state_s  = ST_SCAN;
         rate_s   = forced_s;
         locked_s = 1'b0;
         dwell_s  = '0;
         trs_s    = '0;
         loss_s   = '0;
      end else begin
         if (force_rate_en) begin
            rate_s = forced_s;
         end else begin
            rate_s = rate_r;
         end

         case (state_r)
            ST_SCAN: begin
               if (rx.vid_active) begin
                  state_s = ST_VERIFY;
                  dwell_s = '0;
                  trs_s   = '0;
               end else if (dwell_exp_s) begin
                  dwell_s = '0;
                  rate_s  = next_rate_s;
               end else begin
                  dwell_s = dwell_r + DWELL_W'(1);
               end
            end
            ST_VERIFY: begin
               if (rx.eav_error | rx.sav_error | ~rx.vid_active) begin
                  state_s = ST_SCAN;
                  dwell_s = '0;
                  trs_s   = '0;
               end else if (clean_trs_s && (trs_r == TRS_W'(TRS_GOOD - 1))) begin
                  state_s  = ST_LOCKED;
                  locked_s = 1'b1;
                  dwell_s  = '0;
                  trs_s    = '0;
               end else if (dwell_exp_s) begin
                  state_s = ST_SCAN;
                  dwell_s = '0;
                  trs_s   = '0;
                  rate_s  = next_rate_s;
               end else begin
                  dwell_s = dwell_r + DWELL_W'(1);
                  trs_s   = trs_r + TRS_W'(clean_trs_s);
               end
            end
            ST_LOCKED: begin
               if ((rx.y1_crc_error | rx.c1_crc_error) && (crc_r != 16'hFFFF)) begin
                  crc_s = crc_r + 16'd1;
               end else begin
                  crc_s = crc_r;
               end
               if (~rx.vid_active | ~match_s) begin
                  state_s = ST_LOST;
                  loss_s  = '0;
               end else begin
                  state_s = ST_LOCKED;
               end
            end
            ST_LOST: begin
               // Hysteresis expiry takes priority over a same-cycle recovery.
               if (loss_r == LOSS_W'(LOSS_CYCLES - 1)) begin
                  state_s  = ST_SCAN;
                  locked_s = 1'b0;
                  loss_s   = '0;
                  dwell_s  = '0;
                  relock_s = (relock_r == 8'hFF) ? relock_r : relock_r + 8'd1;
               end else if (rx.vid_active && match_s) begin
                  state_s = ST_LOCKED;
                  loss_s  = '0;
               end else begin
                  loss_s = loss_r + LOSS_W'(1);
               end
            end
            default: begin
               state_s  = ST_SCAN;
               locked_s = 1'b0;
               dwell_s  = '0;
               trs_s    = '0;
               loss_s   = '0;
            end
         endcase
      end
   end

   assign rx.rx_rate      = rate_r;
   assign locked          = locked_r;
   assign scan_state      = state_r;
   assign relock_count    = relock_r;
   assign crc_err_count   = crc_r;

endmodule

// File: doc/sdi_rx_rate_scan.md
SDI_RX_RATE_SCAN -- requirements
Module: sdi_rx_rate_scan

Interface
REQ-001 Parameter DWELL_CYCLES, default 65536: cycles spent on one rate waiting for vid_active before advancing.
REQ-002 Parameter TRS_GOOD, default 8: consecutive error-free TRS pulses required to declare lock.
REQ-003 Parameter LOSS_CYCLES, default 4096: hysteresis cycles tolerated in LOST before rescanning.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 rx_clk  in  1  receiver clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 vid_active  in  1  receiver locked-to-video indication.
REQ-008 trs_out  in  1  one-cycle pulse per EAV/SAV detected.
REQ-009 eav_error, sav_error  in  1 each  TRS protection error pulses.
REQ-010 y1_crc_error, c1_crc_error  in  1 each  line CRC error pulses.
REQ-011 rx_tg_hdn, rx_hd_sdn  in  1 each  receiver-reported standard.
REQ-012 force_rate_en  in  1  manual rate override enable.
REQ-013 force_rate  in  2  override rate: 0=SD, 1=HD, 2=3G, 3 treated as 3G.
REQ-014 rx_rate  out  3  one-hot receiver scan control {3G,HD,SD}; drives receiver rx_rate.
REQ-015 locked  out  1  stable lock indication.
REQ-016 scan_state  out  2  0=SCAN, 1=VERIFY, 2=LOCKED, 3=LOST.
REQ-017 relock_count  out  8  saturating count of LOST->SCAN transitions.
REQ-018 crc_err_count  out  16  saturating count of CRC error cycles while LOCKED.

Function
REQ-019 All outputs registered; rx_rate is always exactly one-hot.
REQ-020 Automatic scan order 3G(100) -> HD(010) -> SD(001) -> 3G; rate change visible the cycle after the deciding event.
REQ-021 SCAN: dwell counter increments each cycle; vid_active=1 -> VERIFY, dwell and TRS counters cleared.
REQ-022 SCAN: dwell counter = DWELL_CYCLES-1 with vid_active=0 -> advance rate, dwell counter to 0, stay SCAN.
REQ-023 SCAN: vid_active=1 in the dwell-expiry cycle -> VERIFY wins, rate not advanced.
REQ-024 VERIFY: each trs_out with eav_error=sav_error=0 increments TRS counter; reaching TRS_GOOD -> LOCKED, locked=1 next cycle.
REQ-025 VERIFY: eav_error or sav_error, or vid_active=0 -> SCAN, same rate, TRS and dwell counters cleared.
REQ-026 VERIFY: dwell counter keeps running; expiry -> SCAN with rate advanced (unless forced).
REQ-027 LOCKED: rate mismatch (3G needs rx_tg_hdn=1; HD needs rx_tg_hdn=0,rx_hd_sdn=1; SD needs rx_hd_sdn=0) or vid_active=0 -> LOST.
REQ-028 LOCKED: any cycle with y1_crc_error or c1_crc_error increments crc_err_count by 1, saturating at 0xFFFF.
REQ-029 LOST: locked stays 1; loss counter increments; vid_active=1 and rate match -> LOCKED, loss counter cleared.
REQ-030 LOST: loss counter = LOSS_CYCLES-1 -> SCAN same rate, locked=0, relock_count+1 saturating at 0xFF.
REQ-031 force_rate_en=1: rx_rate follows force_rate; dwell expiry never advances rate (counter wraps to 0).
REQ-032 Rising edge of force_rate_en, or force_rate change while enabled, from any state -> SCAN with forced rate, locked=0, counters cleared except relock_count and crc_err_count.
REQ-033 Falling edge of force_rate_en -> scan resumes from current rate, state unchanged.

Reset
REQ-034 rst=1 at any edge, including mid-operation: scan_state=SCAN, rx_rate=100, locked=0, relock_count=0, crc_err_count=0, all internal counters 0.
REQ-035 First state transition possible on the cycle after rst deasserts.

Verification
REQ-036 DWELL_CYCLES=16, vid_active=0 for 50 cycles after reset -> rx_rate 100, then 010 at cycle 16, 001 at 32, 100 at 48.
REQ-037 vid_active=1 on HD, 8 clean trs_out pulses -> scan_state 1 then 2, locked=1 one cycle after the 8th pulse, rx_rate stays 010.
REQ-038 In VERIFY after 5 pulses, eav_error with trs_out -> scan_state=0, rx_rate unchanged, TRS count restarts at 0.
REQ-039 LOCKED at 3G, vid_active drop for LOSS_CYCLES-2 cycles then restore -> locked stays 1, back to LOCKED, relock_count=0; drop for LOSS_CYCLES -> SCAN, locked=0, relock_count=1.
REQ-040 force_rate_en=1, force_rate=0 during LOCKED at HD -> SCAN, rx_rate=001 next cycle, no advance across 3 dwell expiries.
REQ-041 LOCKED with c1_crc_error held 70000 cycles -> crc_err_count=0xFFFF; rst mid-run -> all outputs at reset values next cycle.
